mm_stream: RTL and testbench

MM_STREAM -- requirements
Module: mm_stream

---
 rtl/mm_stream.sv | 254 +++++++++++++++++++++++++
 tb/tb_mm_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mm_stream.sv
// mm_stream -- streaming signed matrix multiplier, C = A * B.
//
// Two matrices are streamed in row-major order, one element per clock while
// busy is low: first A (m x n), then B (n x p). col_end marks the last element
// of a row; col_end together with row_end marks the last element of a matrix.
// Shapes are checked once B is complete. A legal pair produces m*p results in
// row-major order, one every n+1 cycles; an illegal pair produces a single
// pulse with is_legal low. Inputs are ignored (not buffered) while busy.
//
// Parameters:
//   DATA_W  - input element width (signed)
//   MAX_DIM - largest row/column count accepted for either operand (2..16)
//   OUT_W   - result width (signed)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous reset, active low
//   in_data    - streamed matrix element
//   col_end    - element is the last of its row
//   row_end    - with col_end, element is the last of its matrix
//   out_data   - result element (0 when valid is low)
//   is_legal   - multiplication legal, qualified by valid
//   change_row - out_data is the last element of a result row
//   valid      - out_data/is_legal/change_row meaningful this cycle
//   busy       - inputs ignored while high
//
// Build option: define MM_STREAM_SATURATE_EN to clamp results to the OUT_W
// signed range; otherwise results wrap to the low OUT_W bits.

module mm_stream #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 4,
    parameter int OUT_W   = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     col_end,
    input  logic                     row_end,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     is_legal,
    output logic                     change_row,
    output logic                     valid,
    output logic                     busy
);

    localparam int IW    = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    // Counters must represent MAX_DIM+1 so oversize shapes stay detectable.
    localparam int CW    = $clog2(MAX_DIM + 2);
    localparam int ACC_W = 2 * DATA_W + $clog2(MAX_DIM);
    localparam int PW    = 2 * DATA_W;

    localparam logic [CW-1:0] DIM_MAX = CW'(MAX_DIM);
    localparam logic [CW-1:0] DIM_OVF = CW'(MAX_DIM + 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [2:0] {
        READ_A,
        READ_B,
        CHECK,
        MAC,
        OUT,
        ILLEGAL
    } state_t;

    state_t state, state_nxt;

    // Shape tracking for the matrix currently being read
    logic [CW-1:0] col_cnt, row_cnt, first_cols;
    logic          shape_bad;

    // Captured shapes
    logic [CW-1:0] a_rows, a_cols, b_rows, b_cols;
    logic          a_bad, b_bad;

    // Compute indices and accumulator
    logic [CW-1:0]           i_idx, j_idx, k_idx;
    logic signed [ACC_W-1:0] acc;
    logic signed [PW-1:0]    prod;

    logic signed [DATA_W-1:0] a_mem [MAX_DIM][MAX_DIM];
    logic signed [DATA_W-1:0] b_mem [MAX_DIM][MAX_DIM];

    logic          reading, row_done, mat_done, row_bad, mat_bad, legal;
    logic          last_col, last_row, last_k;
    logic [CW-1:0] row_len, rows_now, mat_cols;
    logic signed [OUT_W-1:0] result;

    assign reading  = (state == READ_A) || (state == READ_B);
    assign row_done = reading && col_end;
    assign mat_done = row_done && row_end;

    // Length of the row including the current element, saturating at MAX_DIM+1
    assign row_len  = (col_cnt == DIM_OVF) ? DIM_OVF : col_cnt + ONE;
    assign rows_now = (row_cnt == DIM_OVF) ? DIM_OVF : row_cnt + ONE;
    assign mat_cols = (row_cnt == '0) ? row_len : first_cols;
    assign row_bad  = (row_len > DIM_MAX) || ((row_cnt != '0) && (row_len != first_cols));
    assign mat_bad  = shape_bad || row_bad || (rows_now > DIM_MAX);

    assign legal    = !a_bad && !b_bad && (a_cols == b_rows);
    assign last_k   = (k_idx == a_cols - ONE);
    assign last_col = (j_idx == b_cols - ONE);
    assign last_row = (i_idx == a_rows - ONE);

    assign prod = PW'(a_mem[i_idx[IW-1:0]][k_idx[IW-1:0]]) *
                  PW'(b_mem[k_idx[IW-1:0]][j_idx[IW-1:0]]);

`ifdef MM_STREAM_SATURATE_EN
    localparam int WW = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [WW-1:0] SAT_MAX = {{(WW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_MIN = {{(WW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    logic signed [WW-1:0] acc_ext;

    assign acc_ext = WW'(acc);
    always_comb begin
        if (acc_ext > SAT_MAX)
            result = SAT_MAX[OUT_W-1:0];
        else if (acc_ext < SAT_MIN)
            result = SAT_MIN[OUT_W-1:0];
        else
            result = acc_ext[OUT_W-1:0];
    end
`else
    // Sign-extends when OUT_W is wider than the accumulator, wraps otherwise
    assign result = OUT_W'(acc);
`endif

    // Element storage; out-of-range elements of an oversize matrix are dropped
    always_ff @(posedge clk) begin
        if (reading && (col_cnt < DIM_MAX) && (row_cnt < DIM_MAX)) begin
            if (state == READ_A)
                a_mem[row_cnt[IW-1:0]][col_cnt[IW-1:0]] <= in_data;
            else
                b_mem[row_cnt[IW-1:0]][col_cnt[IW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= READ_A;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        valid      = 1'b0;
        is_legal   = 1'b0;
        change_row = 1'b0;
        out_data   = '0;
        case (state)
            READ_A: begin
                busy = 1'b0;
                if (mat_done)
                    state_nxt = READ_B;
            end
            READ_B: begin
                busy = 1'b0;
                if (mat_done)
                    state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = legal ? MAC : ILLEGAL;
            end
            MAC: begin
                if (last_k)
                    state_nxt = OUT;
            end
            OUT: begin
                valid      = 1'b1;
                is_legal   = 1'b1;
                change_row = last_col;
                out_data   = result;
                state_nxt  = (last_col && last_row) ? READ_A : MAC;
            end
            ILLEGAL: begin
                valid     = 1'b1;
                state_nxt = READ_A;
            end
            default: state_nxt = READ_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            first_cols <= '0;
            shape_bad  <= 1'b0;
            a_rows     <= '0;
            a_cols     <= '0;
            a_bad      <= 1'b0;
            b_rows     <= '0;
            b_cols     <= '0;
            b_bad      <= 1'b0;
            i_idx      <= '0;
            j_idx      <= '0;
            k_idx      <= '0;
            acc        <= '0;
        end else begin
            case (state)
                READ_A, READ_B: begin
                    if (mat_done) begin
                        if (state == READ_A) begin
                            a_rows <= rows_now;
                            a_cols <= mat_cols;
                            a_bad  <= mat_bad;
                        end else begin
                            b_rows <= rows_now;
                            b_cols <= mat_cols;
                            b_bad  <= mat_bad;
                        end
                        col_cnt    <= '0;
                        row_cnt    <= '0;
                        first_cols <= '0;
                        shape_bad  <= 1'b0;
                    end else if (row_done) begin
                        col_cnt <= '0;
                        row_cnt <= rows_now;
                        if (row_cnt == '0)
                            first_cols <= row_len;
                        if (row_bad)
                            shape_bad <= 1'b1;
                    end else begin
                        col_cnt <= row_len;
                    end
                end
                CHECK: begin
                    i_idx <= '0;
                    j_idx <= '0;
                    k_idx <= '0;
                    acc   <= '0;
                end
                MAC: begin
                    acc   <= acc + ACC_W'(prod);
                    k_idx <= k_idx + ONE;
                end
                OUT: begin
                    acc   <= '0;
                    k_idx <= '0;
                    if (last_col) begin
                        j_idx <= '0;
                        i_idx <= i_idx + ONE;
                    end else begin
                        j_idx <= j_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_stream.sv
module tb_mm_stream;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              col_end = 1'b0;
    logic              row_end = 1'b0;

    logic signed [19:0] out_data;
    logic               is_legal, change_row, valid, busy;
    logic signed [15:0] out_data_16;
    logic               is_legal_16, change_row_16, valid_16, busy_16;

    int n_checks = 0;
    int n_fail   = 0;

    // Results captured by collect()
    int                 nv, stray, end_cyc;
    logic               tmo, idle_ok;
    logic signed [19:0] rv   [16];
    logic signed [15:0] rv16 [16];
    logic               rcr  [16];
    logic               rleg [16];
    int                 rt   [16];

    int exp2x2 [4] = '{19, 22, 43, 50};

    always #5 clk = ~clk;

    mm_stream #(.DATA_W(8), .MAX_DIM(4), .OUT_W(20)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .col_end(col_end), .row_end(row_end),
        .out_data(out_data), .is_legal(is_legal), .change_row(change_row),
        .valid(valid), .busy(busy)
    );

    mm_stream #(.DATA_W(8), .MAX_DIM(4), .OUT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data), .col_end(col_end), .row_end(row_end),
        .out_data(out_data_16), .is_legal(is_legal_16), .change_row(change_row_16),
        .valid(valid_16), .busy(busy_16)
    );

    task automatic send(input logic signed [7:0] d, input logic ce, input logic re);
        in_data = d; col_end = ce; row_end = re;
        @(posedge clk); #1;
    endtask

    task automatic send_2x2();
        send(8'sd1, 0, 0); send(8'sd2, 1, 0); send(8'sd3, 0, 0); send(8'sd4, 1, 1);
        send(8'sd5, 0, 0); send(8'sd6, 1, 0); send(8'sd7, 0, 0); send(8'sd8, 1, 1);
    endtask

    // Runs from the CHECK cycle until busy drops; cycle 0 is CHECK.
    // Junk elements are driven throughout to show they are discarded.
    task automatic collect(input int budget);
        int cyc;
        nv = 0; stray = 0; cyc = 0;
        while (busy && cyc < budget) begin
            in_data = 8'sd99; col_end = 1'b1; row_end = 1'b1;
            if (valid) begin
                if (nv < 16) begin
                    rv[nv] = out_data; rv16[nv] = out_data_16;
                    rcr[nv] = change_row; rleg[nv] = is_legal; rt[nv] = cyc;
                end
                nv++;
            end else if (out_data !== '0 || is_legal !== 1'b0 || change_row !== 1'b0) begin
                stray++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        tmo = busy;
        end_cyc = cyc;
        idle_ok = (valid === 1'b0) && (out_data === '0);
    endtask

    task automatic check_2x2(input string tag);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: busy still %0b after budget", tag, tmo); end
        n_checks++; if (nv != 4) begin n_fail++; $display("FAIL %s_count: got %0d valid, expected 4", tag, nv); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rv[k] !== 20'(exp2x2[k])) begin n_fail++; $display("FAIL %s_data[%0d]: got %0d expected %0d", tag, k, rv[k], exp2x2[k]); end
            n_checks++; if (rcr[k] !== logic'(k % 2 == 1)) begin n_fail++; $display("FAIL %s_change_row[%0d]: got %0b expected %0b", tag, k, rcr[k], k % 2 == 1); end
            n_checks++; if (rleg[k] !== 1'b1) begin n_fail++; $display("FAIL %s_legal[%0d]: got %0b expected 1", tag, k, rleg[k]); end
            n_checks++; if (rt[k] != 3 * (k + 1)) begin n_fail++; $display("FAIL %s_time[%0d]: got cycle %0d expected %0d", tag, k, rt[k], 3 * (k + 1)); end
        end
        n_checks++; if (end_cyc != 13) begin n_fail++; $display("FAIL %s_busy_drop: got cycle %0d expected 13", tag, end_cyc); end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL %s_idle_outputs: %0d nonzero idle cycles, expected 0", tag, stray); end
        n_checks++; if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL %s_after_outputs: valid %0b out %0d, expected 0 0", tag, valid, out_data); end
    endtask

    task automatic check_illegal(input string tag);
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL %s_count: got %0d valid, expected 1", tag, nv); end
        n_checks++; if (rleg[0] !== 1'b0) begin n_fail++; $display("FAIL %s_legal: got %0b expected 0", tag, rleg[0]); end
        n_checks++; if (rv[0] !== 20'sd0) begin n_fail++; $display("FAIL %s_data: got %0d expected 0", tag, rv[0]); end
        n_checks++; if (rcr[0] !== 1'b0) begin n_fail++; $display("FAIL %s_change_row: got %0b expected 0", tag, rcr[0]); end
        n_checks++; if (rt[0] != 1) begin n_fail++; $display("FAIL %s_time: got cycle %0d expected 1", tag, rt[0]); end
        n_checks++; if (end_cyc != 2 || tmo !== 1'b0) begin n_fail++; $display("FAIL %s_busy_drop: got cycle %0d expected 2", tag, end_cyc); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        n_checks++; if (out_data !== '0 || is_legal !== 1'b0 || change_row !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: out %0d legal %0b cr %0b expected 0 0 0", out_data, is_legal, change_row); end
        rst = 1'b1;
    endtask

    task automatic test_basic_2x2();
        send_2x2();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %0b expected 1", busy); end
        collect(40);
        check_2x2("basic");
    endtask

    task automatic test_illegal_dim();
        send(8'sd1, 0, 0); send(8'sd2, 0, 0); send(8'sd3, 1, 0);
        send(8'sd4, 0, 0); send(8'sd5, 0, 0); send(8'sd6, 1, 1);
        send(8'sd1, 0, 0); send(8'sd2, 1, 0); send(8'sd3, 0, 0); send(8'sd4, 1, 1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL illegal_busy_rise: got %0b expected 1", busy); end
        collect(20);
        check_illegal("illegal_dim");
    endtask

    task automatic test_back_to_back();
        send_2x2();
        collect(40);
        check_2x2("back_to_back");
    endtask

    task automatic test_neg_1x4();
        logic signed [15:0] exp16;
`ifdef MM_STREAM_SATURATE_EN
        exp16 = 16'sd32767;
`else
        exp16 = 16'sd0;
`endif
        // row_end without col_end is an ordinary element
        send(-8'sd128, 0, 1); send(-8'sd128, 0, 0); send(-8'sd128, 0, 0); send(-8'sd128, 1, 1);
        send(-8'sd128, 1, 0); send(-8'sd128, 1, 0); send(-8'sd128, 1, 0); send(-8'sd128, 1, 1);
        collect(20);
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL neg_count: got %0d valid, expected 1", nv); end
        n_checks++; if (rv[0] !== 20'sd65536) begin n_fail++; $display("FAIL neg_data: got %0d expected 65536", rv[0]); end
        n_checks++; if (rcr[0] !== 1'b1 || rleg[0] !== 1'b1) begin n_fail++; $display("FAIL neg_flags: cr %0b legal %0b expected 1 1", rcr[0], rleg[0]); end
        n_checks++; if (rt[0] != 5) begin n_fail++; $display("FAIL neg_time: got cycle %0d expected 5", rt[0]); end
        n_checks++; if (rv16[0] !== exp16) begin n_fail++; $display("FAIL neg_out16: got %0d expected %0d", rv16[0], exp16); end
    endtask

    task automatic test_shape_errors();
        send(8'sd1, 0, 0); send(8'sd2, 0, 0); send(8'sd3, 0, 0); send(8'sd4, 0, 0); send(8'sd5, 1, 1);
        send(8'sd7, 1, 1);
        collect(20);
        check_illegal("too_wide");
        send(8'sd1, 0, 0); send(8'sd2, 1, 0); send(8'sd3, 0, 0); send(8'sd4, 0, 0); send(8'sd5, 1, 1);
        send(8'sd1, 1, 0); send(8'sd1, 1, 1);
        collect(20);
        check_illegal("ragged");
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_2x2();
        cyc = 0;
        while (!valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (valid !== 1'b1 || out_data !== 20'sd19) begin n_fail++; $display("FAIL mid_first: valid %0b out %0d expected 1 19", valid, out_data); end
        @(posedge clk); #2;
        in_data = '0; col_end = 1'b0; row_end = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ctrl: valid %0b busy %0b expected 0 0", valid, busy); end
        n_checks++; if (out_data !== '0 || is_legal !== 1'b0 || change_row !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: out %0d legal %0b cr %0b expected 0 0 0", out_data, is_legal, change_row); end
        @(posedge clk); #1;
        rst = 1'b1;
        send_2x2();
        collect(40);
        check_2x2("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic_2x2();
        test_illegal_dim();
        test_back_to_back();
        test_neg_1x4();
        test_shape_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
